// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch front end with in-order request tracking and redirect handling
module fetch_stage #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter int          DEPTH     = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        valid_out,
   input  logic        ready_in,
   output logic [31:0] PC_IF,
   output logic [31:0] IR_IF,
   input  logic        jump_pred_IF,
   input  logic [31:0] jump_addr_IF,
   input  logic        flush_EX,
   input  logic [31:0] jump_addr_EX
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]   fetch_pc;
   logic [31:0]   pc_q [DEPTH];
   logic [AW-1:0] pq_wr, pq_rd;
   logic [31:0]   fifo_pc [DEPTH];
   logic [31:0]   fifo_ir [DEPTH];
   logic [AW-1:0] of_wr, of_rd;
   logic [CW-1:0] occ, inflight, drop, inflight_n;
   logic [CW:0]   budget;
   logic          req_ok, accept, pop_raw, pop, pred_redirect, push;
   logic          unused_addr_bits;

   assign unused_addr_bits = ^{jump_addr_IF[1:0], jump_addr_EX[1:0]};

   assign valid_out = (occ != '0);
   assign PC_IF     = valid_out ? fifo_pc[of_rd] : 32'h0;
   assign IR_IF     = valid_out ? fifo_ir[of_rd] : 32'h0;

   assign pop_raw       = valid_out && ready_in;
   assign pop           = pop_raw && !flush_EX;
   assign pred_redirect = pop && jump_pred_IF;

   // Count a slot being vacated this cycle so streaming keeps one word per cycle.
   assign budget = {1'b0, inflight} + {1'b0, occ} - (CW+1)'(pop_raw);
   assign req_ok = (budget < (CW+1)'(DEPTH));

   assign imem_req_valid = reset && req_ok;
   assign imem_addr      = fetch_pc;
   assign accept         = req_ok && imem_req_ready;

   assign inflight_n = inflight + CW'(accept) - CW'(imem_rsp_valid);

   // Words arriving in a redirect cycle are always wrong-path and never stored.
   assign push = imem_rsp_valid && (drop == '0) && !flush_EX && !pred_redirect;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc <= RESET_VEC;
         pq_wr    <= '0;
         pq_rd    <= '0;
         of_wr    <= '0;
         of_rd    <= '0;
         occ      <= '0;
         inflight <= '0;
         drop     <= '0;
      end else begin
         inflight <= inflight_n;
         if (accept)
            pq_wr <= pq_wr + AW'(1);
         if (imem_rsp_valid)
            pq_rd <= pq_rd + AW'(1);

         if (flush_EX)
            fetch_pc <= {jump_addr_EX[31:2], 2'b00};
         else if (pred_redirect)
            fetch_pc <= {jump_addr_IF[31:2], 2'b00};
         else if (accept)
            fetch_pc <= fetch_pc + 32'd4;

         if (flush_EX || pred_redirect) begin
            drop  <= inflight_n;
            occ   <= '0;
            of_rd <= of_wr;
         end else begin
            if (imem_rsp_valid && (drop != '0))
               drop <= drop - CW'(1);
            if (push)
               of_wr <= of_wr + AW'(1);
            if (pop)
               of_rd <= of_rd + AW'(1);
            occ <= occ + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         pc_q[pq_wr] <= fetch_pc;
      if (push) begin
         fifo_pc[of_wr] <= pc_q[pq_rd];
         fifo_ir[of_wr] <= imem_rsp_data;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
   localparam logic [31:0] MASK = 32'hA5A5_0F0F;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        valid_out;
   logic        ready_in;
   logic [31:0] PC_IF;
   logic [31:0] IR_IF;
   logic        jump_pred_IF;
   logic [31:0] jump_addr_IF;
   logic        flush_EX;
   logic [31:0] jump_addr_EX;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_VEC(32'h0000_0100), .DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .valid_out(valid_out), .ready_in(ready_in), .PC_IF(PC_IF), .IR_IF(IR_IF),
      .jump_pred_IF(jump_pred_IF), .jump_addr_IF(jump_addr_IF),
      .flush_EX(flush_EX), .jump_addr_EX(jump_addr_EX)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mq[$];
   logic [31:0] deliv[$];
   logic [31:0] dir[$];
   logic [31:0] acc_log[$];
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int lat = 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] d_at(input int i);
      return (i < deliv.size()) ? deliv[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] r_at(input int i);
      return (i < dir.size()) ? dir[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] a_at(input int i);
      return (i < acc_log.size()) ? acc_log[i] : 32'hDEAD_BEEF;
   endfunction

   // One clock: present the due memory response, log handshakes, cross the edge.
   task automatic step();
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mq[0].addr ^ MASK;
         void'(mq.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
      #1;
      if (imem_req_valid && imem_req_ready) begin
         mq.push_back('{addr: imem_addr, due: cyc + lat});
         acc_log.push_back(imem_addr);
      end
      if (valid_out && ready_in && !flush_EX) begin
         deliv.push_back(PC_IF);
         dir.push_back(IR_IF);
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic hold_reset();
      reset          = 1'b0;
      imem_req_ready = 1'b1;
      ready_in       = 1'b1;
      jump_pred_IF   = 1'b0;
      jump_addr_IF   = 32'h0;
      flush_EX       = 1'b0;
      jump_addr_EX   = 32'h0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      mq.delete();
      deliv.delete();
      dir.delete();
      acc_log.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic release_reset();
      reset = 1'b1;
      #1;
   endtask

   initial begin
      // 1: reset state and streaming at 1 word/cycle
      lat = 1;
      hold_reset();
      chk("rst_valid_out", 32'(valid_out), 32'h0);
      chk("rst_pc_if", PC_IF, 32'h0);
      chk("rst_ir_if", IR_IF, 32'h0);
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      release_reset();
      chk("t1_req_valid", 32'(imem_req_valid), 32'h1);
      chk("t1_addr0", imem_addr, 32'h100);
      step();
      chk("t1_addr1", imem_addr, 32'h104);
      chk("t1_no_bypass", 32'(valid_out), 32'h0);
      step();
      chk("t1_valid_c2", 32'(valid_out), 32'h1);
      chk("t1_pc0", PC_IF, 32'h100);
      chk("t1_ir0", IR_IF, 32'h100 ^ MASK);
      step();
      chk("t1_valid_c3", 32'(valid_out), 32'h1);
      chk("t1_pc1", PC_IF, 32'h104);

      // 2: predicted-taken redirect while PC_IF = 0x104
      jump_pred_IF = 1'b1;
      jump_addr_IF = 32'h200;
      step();
      jump_pred_IF = 1'b0;
      chk("t2_addr_after_pred", imem_addr, 32'h200);
      chk("t2_valid_after_pred", 32'(valid_out), 32'h0);
      step();
      step();
      chk("t2_pc_target", PC_IF, 32'h200);
      step();
      step();
      chk("t2_deliv_count", 32'(deliv.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         logic [31:0] e;
         e = (i < 2) ? 32'h100 + 32'(4 * i) : 32'h200 + 32'(4 * (i - 2));
         chk($sformatf("t2_deliv_pc%0d", i), d_at(i), e);
         chk($sformatf("t2_deliv_ir%0d", i), r_at(i), e ^ MASK);
      end
      chk("t1_acc0", a_at(0), 32'h100);
      chk("t1_acc1", a_at(1), 32'h104);
      chk("t1_acc2", a_at(2), 32'h108);

      // 3: 3-cycle memory, EX flush with two requests in flight
      lat = 3;
      hold_reset();
      release_reset();
      step();
      step();
      chk("t3_stall_two_inflight", 32'(imem_req_valid), 32'h0);
      flush_EX     = 1'b1;
      jump_addr_EX = 32'h303;
      step();
      flush_EX = 1'b0;
      chk("t3_addr_after_flush", imem_addr, 32'h300);
      chk("t3_req_blocked", 32'(imem_req_valid), 32'h0);
      repeat (8) step();
      chk("t3_deliv_count", 32'(deliv.size()), 32'd2);
      chk("t3_first_pc", d_at(0), 32'h300);
      chk("t3_first_ir", r_at(0), 32'h300 ^ MASK);
      chk("t3_second_pc", d_at(1), 32'h304);
      chk("t3_acc_after_flush", a_at(2), 32'h300);

      // 4: downstream stall for 5 cycles
      lat = 1;
      hold_reset();
      release_reset();
      repeat (4) step();
      chk("t4_pc_before_stall", PC_IF, 32'h108);
      ready_in = 1'b0;
      #1;
      chk("t4_req_drops", 32'(imem_req_valid), 32'h0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("t4_hold_pc%0d", i), PC_IF, 32'h108);
         chk($sformatf("t4_hold_ir%0d", i), IR_IF, 32'h108 ^ MASK);
      end
      chk("t4_req_off_full", 32'(imem_req_valid), 32'h0);
      ready_in = 1'b1;
      repeat (6) step();
      chk("t4_deliv_count", 32'(deliv.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("t4_order%0d", i), d_at(i), 32'h100 + 32'(4 * i));

      // 5: memory backpressure holds the address
      hold_reset();
      release_reset();
      imem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("t5_hold_valid%0d", i), 32'(imem_req_valid), 32'h1);
         chk($sformatf("t5_hold_addr%0d", i), imem_addr, 32'h100);
         step();
      end
      imem_req_ready = 1'b1;
      repeat (4) step();
      chk("t5_acc0", a_at(0), 32'h100);
      chk("t5_acc1", a_at(1), 32'h104);
      chk("t5_deliv_count", 32'(deliv.size()), 32'd2);
      chk("t5_deliv0", d_at(0), 32'h100);
      chk("t5_deliv1", d_at(1), 32'h104);

      // 6: EX flush beats a same-cycle prediction
      hold_reset();
      release_reset();
      step();
      step();
      chk("t6_pc_before", PC_IF, 32'h100);
      flush_EX     = 1'b1;
      jump_addr_EX = 32'h400;
      jump_pred_IF = 1'b1;
      jump_addr_IF = 32'h500;
      step();
      flush_EX     = 1'b0;
      jump_pred_IF = 1'b0;
      chk("t6_valid_cleared", 32'(valid_out), 32'h0);
      chk("t6_addr", imem_addr, 32'h400);
      step();
      step();
      chk("t6_pc_target", PC_IF, 32'h400);
      chk("t6_no_pops", 32'(deliv.size()), 32'd0);

      // 7: asynchronous reset mid-stream
      hold_reset();
      release_reset();
      repeat (5) step();
      reset = 1'b0;
      #1;
      chk("t7_async_valid", 32'(valid_out), 32'h0);
      chk("t7_async_pc", PC_IF, 32'h0);
      chk("t7_async_req", 32'(imem_req_valid), 32'h0);
      hold_reset();
      release_reset();
      chk("t7_restart_addr", imem_addr, 32'h100);
      step();
      step();
      chk("t7_restart_pc", PC_IF, 32'h100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch front end. It generates the fetch PC, issues in-order requests to instruction memory, and buffers returned words. It presents {PC_IF, IR_IF} to the IF-stage decode/branch-prediction logic and the IF/ID handshake. It redirects on a predicted-taken jump from the branch predictor and on an EX-stage correction, discarding wrong-path words.

Parameters:
RESET_VEC, 32'h00000000, first fetch address after reset.
DEPTH, 2, max in-flight requests plus buffered words; power of two, >= 2.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
imem_req_valid  out  1  request valid.
imem_req_ready  in  1  memory accepts request.
imem_addr  out  32  request address; bits [1:0] always 0.
imem_rsp_valid  in  1  response valid; in order, one per accepted request, >= 1 cycle later, no backpressure.
imem_rsp_data  in  32  instruction word.
valid_out  out  1  head entry valid toward IF/ID.
ready_in  in  1  downstream accepts head entry.
PC_IF  out  32  PC of head entry; 0 when empty.
IR_IF  out  32  instruction of head entry; 0 when empty.
jump_pred_IF  in  1  predictor: head entry predicted taken (combinational from PC_IF/IR_IF).
jump_addr_IF  in  32  predicted target.
flush_EX  in  1  EX misprediction / redirect.
jump_addr_EX  in  32  corrected target.

Behaviour:
- State: fetch_PC; PC queue (DEPTH) for in-flight requests; output FIFO (DEPTH) of {PC, instr}; inflight counter (0..DEPTH); drop counter (0..DEPTH).
- Reset (reset=0, async): fetch_PC=RESET_VEC, FIFOs empty, counters 0, imem_req_valid=0, valid_out=0, PC_IF=0, IR_IF=0. Memory is reset together with this block; no responses are pending after reset.
- Request:
  - imem_req_valid = inflight + occupancy − pop < DEPTH, where pop = valid_out && ready_in.
  - imem_addr = fetch_PC.
  - Accept = valid && ready: push fetch_PC to the PC queue, inflight+1, fetch_PC += 4 (mod 2^32 wrap).
  - While valid and not ready, imem_addr holds stable.
- Response:
  - If drop>0: discard the word, drop−1, pop the PC queue, inflight−1.
  - Else: push {PC queue head, data} to the output FIFO, pop the PC queue, inflight−1.
- Output:
  - Head of the output FIFO drives PC_IF/IR_IF; valid_out = !empty.
  - Zero-latency bypass is not allowed: a response is visible on valid_out one cycle after imem_rsp_valid.
  - Sustained throughput is 1 word/cycle with DEPTH=2 and 1-cycle memory.
- Predicted redirect (pop && jump_pred_IF && !flush_EX):
  - fetch_PC <= {jump_addr_IF[31:2],2'b00}.
  - Output FIFO entries younger than the head are flushed; the head itself is consumed normally.
  - drop <= inflight + accept − rsp_valid. The response in this cycle and the request accepted this cycle are both wrong-path.
- EX flush (flush_EX=1, highest priority):
  - fetch_PC <= {jump_addr_EX[31:2],2'b00}.
  - Output FIFO cleared, including the head; pop ignored.
  - drop <= inflight + accept − rsp_valid.
  - valid_out=0 the following cycle.
- flush_EX and a predicted redirect in the same cycle: flush_EX wins; jump_addr_IF is ignored.
- Back-to-back flushes recompute drop each cycle with the same formula, so counts never double.
- Output FIFO full with all slots committed: no new requests; ready_in low stalls without loss.
- Invariant for assertions: inflight + occupancy <= DEPTH; drop <= inflight.

Test Plan:
1. RESET_VEC=0x100, 1-cycle memory, ready_in=1:
   - Requests go to 0x100, 0x104, 0x108 on consecutive cycles.
   - PC_IF sequence is 0x100, 0x104, 0x108 with valid_out continuous from the 2nd cycle after reset release.
2. jump_pred_IF=1, jump_addr_IF=0x200 while PC_IF=0x104:
   - Next delivered PC_IF is 0x200; 0x108/0x10C are never presented.
   - Next imem_addr is 0x200.
3. 3-cycle memory, flush_EX with jump_addr_EX=0x303 and 2 requests in flight:
   - Both responses are discarded.
   - Next imem_addr is 0x300; first valid PC_IF is 0x300.
4. ready_in=0 for 5 cycles:
   - imem_req_valid falls once inflight+occupancy=2.
   - PC_IF/IR_IF are held stable.
   - After release, the order is unbroken with no duplicates.
5. imem_req_ready=0 for 3 cycles with request pending:
   - imem_addr is held at the same value, and accepted exactly once.
6. flush_EX (0x400) and jump_pred_IF (0x500) in the same cycle → next PC_IF is 0x400.
7. reset pulled to 0 mid-stream → valid_out=0 and PC_IF=0 immediately (async); after release, fetch restarts at RESET_VEC.
